cru_write_gen: RTL and testbench

Generates TMS9900-style CRU output (LDCR/SBO/SBZ) cycles, the write-direction counterpart of the CRU read generator. Takes a base CRU bit address, a data word and a bit count, then serializes the bits LSB first. For each bit it drives the address and CRUOUT, then pulses CRUCLK. Sits between the mock CPU sequencer and the CRU-mapped peripheral models, clocked by phi2.

---
 rtl/cru_pkg.sv | 29 ++
 rtl/cru_phase_timer.sv | 30 +++
 rtl/cru_write_gen.sv | 148 ++++++++++++++
 tb/tb_cru_write_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cru_pkg.sv
// Shared definitions for the TMS9900-style CRU read and write cycle generators.
package cru_pkg;

    localparam int CRU_ADDR_W = 12;   // CRU bit address (A3..A14)
    localparam int CRU_DATA_W = 16;   // widest LDCR/STCR transfer
    localparam int CRU_CNT_W  = 4;    // bit count field, 0 encodes 16
    localparam int CRU_BUS_W  = 15;   // full address bus width
    localparam int CRU_TMR_W  = 8;    // phase timer width

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } cru_state_e;

    // Expand the 4-bit count field into the real number of bits (0 means 16).
    function automatic logic [CRU_CNT_W:0] cru_expand_count(input logic [CRU_CNT_W-1:0] cnt);
        logic [CRU_CNT_W:0] res;
        if (cnt == '0) begin
            res = (CRU_CNT_W+1)'(CRU_DATA_W);
        end else begin
            res = {1'b0, cnt};
        end
        return res;
    endfunction

endpackage

// File: rtl/cru_phase_timer.sv
// Loadable down-counter with terminal-count flag; times the CRU bus phases.
module cru_phase_timer
    import cru_pkg::*;
#(
    parameter int W = CRU_TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Load on phase entry, otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Terminal count: the current phase ends on the next edge.
    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cru_write_gen.sv
// CRU output cycle generator: serializes a word LSB first as SETUP/STROBE/HOLD
// bus cycles, one CRUCLK pulse per bit, with incrementing bit address.
module cru_write_gen
    import cru_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  phi2,
    input  logic                  reset,
    input  logic                  write_request,
    input  logic [CRU_ADDR_W-1:0] base_addr,
    input  logic [CRU_DATA_W-1:0] wdata,
    input  logic [CRU_CNT_W-1:0]  bit_count,
    output logic [CRU_BUS_W-1:0]  address_bus,
    output logic                  cruout,
    output logic                  cruclk,
    output logic                  busy,
    output logic                  write_done
);

    // Timer reload values: a phase of N cycles loads N-1 and ends at terminal count.
    localparam logic [CRU_TMR_W-1:0] SETUP_LD = CRU_TMR_W'(SETUP_CYC - 1);
    localparam logic [CRU_TMR_W-1:0] PULSE_LD = CRU_TMR_W'(PULSE_CYC - 1);
    localparam logic [CRU_TMR_W-1:0] HOLD_LD  = CRU_TMR_W'(HOLD_CYC - 1);
    localparam logic [CRU_CNT_W:0]   LAST_BIT = (CRU_CNT_W+1)'(1);

    cru_state_e              state_q, state_d;
    logic [CRU_ADDR_W-1:0]   addr_q, addr_d;
    logic [CRU_DATA_W-1:0]   data_q, data_d;
    logic [CRU_CNT_W:0]      bits_q, bits_d;
    logic                    cruclk_q, cruclk_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    tmr_load;
    logic [CRU_TMR_W-1:0]    tmr_val;
    logic                    tmr_tc;

    cru_phase_timer #(
        .W(CRU_TMR_W)
    ) u_timer (
        .clk        (phi2),
        .rst        (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // Next-state and next-output logic; all outputs are taken from registers.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        bits_d   = bits_q;
        cruclk_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (write_request) begin
                    addr_d   = base_addr;
                    data_d   = wdata;
                    bits_d   = cru_expand_count(bit_count);
                    busy_d   = 1'b1;
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (tmr_tc) begin
                    state_d  = STROBE;
                    cruclk_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            STROBE: begin
                cruclk_d = 1'b1;
                if (tmr_tc) begin
                    state_d  = HOLD;
                    cruclk_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_tc) begin
                    if (bits_q == LAST_BIT) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Address and data bit advance together, while CRUCLK is low.
                        state_d  = SETUP;
                        addr_d   = addr_q + CRU_ADDR_W'(1);
                        data_d   = data_q >> 1;
                        bits_d   = bits_q - (CRU_CNT_W+1)'(1);
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            bits_q   <= '0;
            cruclk_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            bits_q   <= bits_d;
            cruclk_q <= cruclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign address_bus = {{(CRU_BUS_W-CRU_ADDR_W){1'b0}}, addr_q};
    assign cruout      = data_q[0];
    assign cruclk      = cruclk_q;
    assign busy        = busy_q;
    assign write_done  = done_q;

endmodule

// File: tb/tb_cru_write_gen.sv
module tb_cru_write_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req2;
    logic [11:0] base;
    logic [15:0] wdata;
    logic [3:0]  cnt;

    logic [14:0] a_bus, a_bus2;
    logic        cruout, cruout2;
    logic        cruclk, cruclk2;
    logic        busy, busy2;
    logic        done, done2;

    always #5 clk = ~clk;

    cru_write_gen #(.SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(1)) dut (
        .phi2(clk), .reset(rst), .write_request(req), .base_addr(base),
        .wdata(wdata), .bit_count(cnt), .address_bus(a_bus), .cruout(cruout),
        .cruclk(cruclk), .busy(busy), .write_done(done)
    );

    cru_write_gen #(.SETUP_CYC(3), .PULSE_CYC(2), .HOLD_CYC(1)) dut2 (
        .phi2(clk), .reset(rst), .write_request(req2), .base_addr(base),
        .wdata(wdata), .bit_count(cnt), .address_bus(a_bus2), .cruout(cruout2),
        .cruclk(cruclk2), .busy(busy2), .write_done(done2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [14:0] addr;
        logic        bit_v;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, want, cyc);
        end else begin
            $display("ok   %s value=0x%0h (cyc %0d)", name, act, cyc);
        end
    endtask

    // Monitor: pops expected (address, bit) at each rising CRUCLK and
    // expected completion cycle at each write_done.
    logic        clk_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [14:0] addr_prev = '0;
    logic        out_prev = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (cruclk && !clk_prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_expected actual=unexpected_strobe addr=0x%0h required=none (cyc %0d)", a_bus, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_addr", 32'(a_bus), 32'(e.addr));
                    check("strobe_cruout", 32'(cruout), 32'(e.bit_v));
                end
            end
            if (cruclk) begin
                check("stable_during_strobe", 32'({a_bus, cruout}), 32'({addr_prev, out_prev}));
            end
            if (done) begin
                check("done_single_cycle", 32'(done_prev), 32'(0));
                check("busy_at_done", 32'(busy), 32'(0));
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_expected actual=unexpected_done required=none (cyc %0d)", cyc);
                end else begin
                    check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
                end
            end
        end
        clk_prev  = cruclk;
        done_prev = done;
        addr_prev = a_bus;
        out_prev  = cruout;
    end

    // Issue one transfer on dut (2/1/1 timing) and load the scoreboard.
    task automatic start(input logic [11:0] b, input logic [15:0] d, input logic [3:0] c);
        int n;
        logic [11:0] a;
        n = (c == 4'd0) ? 16 : int'(c);
        for (int i = 0; i < n; i++) begin
            a = b + 12'(i);
            exp_q.push_back({3'b000, a, d[i]});
        end
        @(negedge clk);
        base  = b;
        wdata = d;
        cnt   = c;
        req   = 1'b1;
        @(negedge clk);
        req = 1'b0;
        done_q.push_back(cyc + n * 4);
        check("busy_after_accept", 32'(busy), 32'(1));
        check("addr_after_accept", 32'(a_bus), 32'({3'b000, b}));
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout actual=still_busy required=idle_within_%0d", name, budget);
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'(0));
    endtask

    int a0;

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        req2  = 1'b0;
        base  = '0;
        wdata = '0;
        cnt   = '0;
        @(negedge clk);
        check("rst_addr", 32'(a_bus), 32'(0));
        check("rst_cruout", 32'(cruout), 32'(0));
        check("rst_cruclk", 32'(cruclk), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three bits 1,0,1 starting at 0x080.
        start(12'h080, 16'h0005, 4'd3);
        wait_idle("t1", 40);

        // Full 16-bit transfer.
        start(12'h100, 16'hA5C3, 4'd0);
        wait_idle("t2", 100);

        // Address wrap.
        start(12'hFFF, 16'h0002, 4'd2);
        wait_idle("t3", 40);

        // Re-request and input changes during bit 1 are ignored.
        start(12'h300, 16'h0006, 4'd3);
        repeat (5) @(negedge clk);
        req   = 1'b1;
        base  = 12'h555;
        wdata = 16'hFFFF;
        cnt   = 4'd7;
        @(negedge clk);
        req = 1'b0;
        wait_idle("t4", 40);
        repeat (10) @(negedge clk);

        // Reset during STROBE of bit 2.
        start(12'h200, 16'h000F, 4'd4);
        a0 = cyc;
        repeat (10) @(negedge clk);
        check("t5_in_strobe", 32'(cruclk), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("t5_rst_cruclk", 32'(cruclk), 32'(0));
        check("t5_rst_busy", 32'(busy), 32'(0));
        check("t5_rst_cruout", 32'(cruout), 32'(0));
        check("t5_rst_done", 32'(done), 32'(0));
        check("t5_rst_addr", 32'(a_bus), 32'(0));
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_idle_busy", 32'(busy), 32'(0));
        start(12'h020, 16'h0009, 4'd4);
        wait_idle("t5_clean", 40);

        // Longer phases on the second instance: S=3, P=2, H=1, one bit.
        @(negedge clk);
        base  = 12'h040;
        wdata = 16'h0001;
        cnt   = 4'd1;
        req2  = 1'b1;
        @(negedge clk);
        req2 = 1'b0;
        a0   = cyc;
        check("t6_busy_accept", 32'(busy2), 32'(1));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t6_cruclk_d%0d", cyc - a0), 32'(cruclk2),
                  32'((cyc - a0 == 3) || (cyc - a0 == 4)));
            check($sformatf("t6_done_d%0d", cyc - a0), 32'(done2), 32'(cyc - a0 == 6));
            if (cyc - a0 == 3) begin
                check("t6_addr", 32'(a_bus2), 32'(15'h040));
                check("t6_cruout", 32'(cruout2), 32'(1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
